// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : video_pattern_gen
// Raster timing generator with noise/bars/gradient/grid test patterns.
// Option   : define PATTERN_SCROLL_EN to scroll gradient and grid per frame.
// Revision : 1.0  initial release
// ============================================================================
module video_pattern_gen #(
  parameter int COLOR_W       = 8,
  parameter int H_ACTIVE      = 320,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 32,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE_NTSC = 240,
  parameter int V_ACTIVE_PAL  = 288,
  parameter int V_FP          = 4,
  parameter int V_SYNC        = 3,
  parameter int V_BP          = 15,
  parameter int CE_DIV        = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pal,
  input  logic               scandouble,
  input  logic [1:0]         mode,
  input  logic [2:0]         col_mask,
  output logic               ce_pix,
  output logic               hblank,
  output logic               vblank,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic [15:0]        frame_cnt
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_VT_NTSC = V_ACTIVE_NTSC + V_FP + V_SYNC + V_BP;
  localparam int c_VT_PAL  = V_ACTIVE_PAL + V_FP + V_SYNC + V_BP;
  localparam int c_VT_MAX  = (c_VT_PAL > c_VT_NTSC) ? c_VT_PAL : c_VT_NTSC;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_VT_MAX);
  localparam int c_DW      = $clog2(CE_DIV);
  localparam int c_BW      = H_ACTIVE / 8;
  localparam int c_SW      = (c_BW > 1) ? $clog2(c_BW) : 1;

  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0] c_VA_N     = c_VW'(V_ACTIVE_NTSC);
  localparam logic [c_VW-1:0] c_VA_P     = c_VW'(V_ACTIVE_PAL);
  localparam logic [c_VW-1:0] c_VL_N     = c_VW'(c_VT_NTSC - 1);
  localparam logic [c_VW-1:0] c_VL_P     = c_VW'(c_VT_PAL - 1);
  localparam logic [c_VW-1:0] c_V_FP     = c_VW'(V_FP);
  localparam logic [c_VW-1:0] c_V_SYNC   = c_VW'(V_SYNC);
  localparam logic [c_DW-1:0] c_DL_N     = c_DW'(CE_DIV - 1);
  localparam logic [c_DW-1:0] c_DL_S     = c_DW'(CE_DIV / 2 - 1);
  localparam logic [c_SW-1:0] c_SEG_LAST = c_SW'(c_BW - 1);

  logic [c_DW-1:0]    div_q, div_d;
  logic               sd_q, sd_d;
  logic [c_HW-1:0]    hc_q, hc_d;
  logic [c_VW-1:0]    vc_q, vc_d;
  logic               pal_q, pal_d;
  logic [1:0]         mode_q, mode_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [c_SW-1:0]    seg_q, seg_d;
  logic [2:0]         bar_q, bar_d;
  logic               ce_q, ce_d;
  logic               hblank_q, hblank_d, vblank_q, vblank_d;
  logic               hsync_q, hsync_d, vsync_q, vsync_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  logic               w_tick, w_h_wrap, w_v_wrap;
  logic               w_hb, w_vb, w_hs, w_vs, w_blank, w_fb;
  logic [c_VW-1:0]    w_v_act, w_v_last, w_vs_beg, w_vs_end;
  logic [c_HW-1:0]    w_x;
  logic [2:0]         w_bar_v;
  logic [COLOR_W-1:0] w_pr, w_pg, w_pb;

`ifdef PATTERN_SCROLL_EN
  assign w_x = hc_q + c_HW'(fcnt_q[7:0]);
`else
  assign w_x = hc_q;
`endif

  assign w_tick   = (div_q == (sd_q ? c_DL_S : c_DL_N));
  assign w_v_act  = pal_q ? c_VA_P : c_VA_N;
  assign w_v_last = pal_q ? c_VL_P : c_VL_N;
  assign w_vs_beg = w_v_act + c_V_FP;
  assign w_vs_end = w_vs_beg + c_V_SYNC;
  assign w_h_wrap = (hc_q == c_H_LAST);
  assign w_v_wrap = (vc_q == w_v_last);
  assign w_hb     = (hc_q >= c_H_ACT);
  assign w_vb     = (vc_q >= w_v_act);
  assign w_hs     = (hc_q >= c_HS_BEG) && (hc_q < c_HS_END);
  assign w_vs     = (vc_q >= w_vs_beg) && (vc_q < w_vs_end);
  assign w_blank  = w_hb | w_vb;
  assign w_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign w_bar_v  = 3'd7 - bar_q;

  always_comb begin
    w_pr = '0;
    w_pg = '0;
    w_pb = '0;
    case (mode_q)
      2'd0: begin
        w_pr = lfsr_q[15 -: COLOR_W];
        w_pg = lfsr_q[15 -: COLOR_W];
        w_pb = lfsr_q[15 -: COLOR_W];
      end
      2'd1: begin
        w_pr = {COLOR_W{w_bar_v[1]}};
        w_pg = {COLOR_W{w_bar_v[2]}};
        w_pb = {COLOR_W{w_bar_v[0]}};
      end
      2'd2: begin
        w_pr = COLOR_W'(w_x);
        w_pg = COLOR_W'(vc_q);
        w_pb = COLOR_W'(fcnt_q);
      end
      default: begin
        if ((w_x[3:0] == 4'd0) || (vc_q[3:0] == 4'd0)) begin
          w_pr = '1;
          w_pg = '1;
          w_pb = '1;
        end
      end
    endcase
  end

  // Every output register samples the current (hc,vc) on the tick, then the counters move on.
  always_comb begin
    div_d    = div_q + c_DW'(1);
    sd_d     = sd_q;
    hc_d     = hc_q;
    vc_d     = vc_q;
    pal_d    = pal_q;
    mode_d   = mode_q;
    fcnt_d   = fcnt_q;
    lfsr_d   = lfsr_q;
    seg_d    = seg_q;
    bar_d    = bar_q;
    ce_d     = 1'b0;
    hblank_d = hblank_q;
    vblank_d = vblank_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    if (w_tick) begin
      div_d    = '0;
      sd_d     = scandouble;
      ce_d     = 1'b1;
      hblank_d = w_hb;
      vblank_d = w_vb;
      hsync_d  = w_hs;
      vsync_d  = w_vs;
      r_d      = (w_blank || !col_mask[2]) ? '0 : w_pr;
      g_d      = (w_blank || !col_mask[1]) ? '0 : w_pg;
      b_d      = (w_blank || !col_mask[0]) ? '0 : w_pb;
      if (!w_blank) begin
        lfsr_d = {lfsr_q[14:0], w_fb};
      end
      if (w_h_wrap) begin
        hc_d  = '0;
        seg_d = '0;
        bar_d = '0;
        if (w_v_wrap) begin
          vc_d   = '0;
          pal_d  = pal;
          mode_d = mode;
          fcnt_d = fcnt_q + 16'd1;
        end else begin
          vc_d = vc_q + c_VW'(1);
        end
      end else begin
        hc_d = hc_q + c_HW'(1);
        if (!w_hb) begin
          if (seg_q == c_SEG_LAST) begin
            seg_d = '0;
            bar_d = bar_q + 3'd1;
          end else begin
            seg_d = seg_q + c_SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= '0;
      sd_q     <= 1'b0;
      hc_q     <= '0;
      vc_q     <= '0;
      pal_q    <= 1'b0;
      mode_q   <= 2'd0;
      fcnt_q   <= 16'd0;
      lfsr_q   <= 16'hACE1;
      seg_q    <= '0;
      bar_q    <= 3'd0;
      ce_q     <= 1'b0;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      div_q    <= div_d;
      sd_q     <= sd_d;
      hc_q     <= hc_d;
      vc_q     <= vc_d;
      pal_q    <= pal_d;
      mode_q   <= mode_d;
      fcnt_q   <= fcnt_d;
      lfsr_q   <= lfsr_d;
      seg_q    <= seg_d;
      bar_q    <= bar_d;
      ce_q     <= ce_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign ce_pix    = ce_q;
  assign hblank    = hblank_q;
  assign vblank    = vblank_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign frame_cnt = fcnt_q;

endmodule
`default_nettype wire
